instr_fetch: RTL

Instruction fetch stage that produces the instruction stream consumed by the decode/control logic. It owns the program counter and drives a synchronous instruction ROM. Fetched words go through a 2-entry buffer to a valid/ready output, so decode back-pressure never drops or duplicates an instruction. Each word is presented with its 3-bit opcode field already split out for the control unit. The block also supports a redirect (branch/jump) and a HALT opcode.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode encodings and fetch FSM states used by the
// fetch stage and the control unit.
package cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_STORE = 3'b100;
  localparam logic [OPC_W-1:0] OPC_HALT  = 3'b111;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetchState_e;

  function automatic logic isHalt(input logic [OPC_W-1:0] opc);
    return (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO between the instruction ROM and decode.
// Flush has priority over push; the head entry is read straight from storage.
module fetch_fifo #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] headData
);

  logic [DATA_W-1:0] mem_r [2];
  logic              rdPtr_r;
  logic              wrPtr_r;
  logic [1:0]        count_r;
  logic              doPush_s;
  logic              doPop_s;

  // Qualify push/pop: a push into a full FIFO is only taken alongside a pop
  always_comb begin
    doPop_s  = pop && (count_r != 2'd0);
    doPush_s = push && !flush && ((count_r != 2'd2) || doPop_s);
  end

  // Entry storage; contents are don't-care once the pointers are cleared
  always_ff @(posedge clk) begin
    if (doPush_s) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr_r <= 1'b0;
      wrPtr_r <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (doPush_s) begin
        wrPtr_r <= ~wrPtr_r;
      end
      if (doPop_s) begin
        rdPtr_r <= ~rdPtr_r;
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count    = count_r;
  assign headData = mem_r[rdPtr_r];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives a synchronous ROM, and hands
// tagged words to decode through a 2-entry FIFO with redirect and HALT support.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  localparam int                ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pcNext_s;
  logic [ADDR_W-1:0]  reqPc_r;
  logic               inflight_r;
  logic               inflightNext_s;
  fetchState_e        state_r;
  fetchState_e        stateNext_s;
  logic [1:0]         count_s;
  logic [2:0]         credit_s;
  logic               pop_s;
  logic               push_s;
  logic               flush_s;
  logic               issue_s;
  logic               capHalt_s;
  logic [ENTRY_W-1:0] head_s;

  assign imem_addr = pc_r;
  assign out_valid = (count_s != 2'd0);
  assign pop_s     = out_valid && out_ready;
  // Slots already spoken for: buffered words plus the outstanding response
  assign credit_s  = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign capHalt_s = inflight_r && isHalt(imem_rdata[INSTR_W-1 -: OPC_W]);

  // Next-state, issue and capture decisions; redirect overrides everything
  always_comb begin
    pcNext_s       = pc_r;
    inflightNext_s = 1'b0;
    stateNext_s    = state_r;
    flush_s        = 1'b0;
    push_s         = 1'b0;
    issue_s        = 1'b0;
    if (redirect_valid) begin
      flush_s     = 1'b1;
      pcNext_s    = redirect_pc;
      stateNext_s = FETCH_RUN;
    end else begin
      push_s = inflight_r;
      case (state_r)
        FETCH_RUN: begin
          // A HALT word arriving now stops the next request immediately
          if (capHalt_s) begin
            stateNext_s = FETCH_HALT;
          end else begin
            issue_s = (credit_s < 3'd2);
          end
        end
        FETCH_HALT: stateNext_s = FETCH_HALT;
        default:    stateNext_s = FETCH_RUN;
      endcase
      if (issue_s) begin
        pcNext_s       = pc_r + PC_ONE;
        inflightNext_s = 1'b1;
      end else begin
        pcNext_s       = pc_r;
        inflightNext_s = 1'b0;
      end
    end
  end

  // PC, request tag, in-flight flag and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      reqPc_r    <= RESET_PC;
      inflight_r <= 1'b0;
      state_r    <= FETCH_RUN;
    end else begin
      pc_r       <= pcNext_s;
      inflight_r <= inflightNext_s;
      state_r    <= stateNext_s;
      if (issue_s) begin
        reqPc_r <= pc_r;
      end
    end
  end

  fetch_fifo #(
    .DATA_W (ENTRY_W)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pushData ({reqPc_r, imem_rdata}),
    .pop      (pop_s),
    .flush    (flush_s),
    .count    (count_s),
    .headData (head_s)
  );

  assign out_pc     = head_s[ENTRY_W-1 -: ADDR_W];
  assign out_instr  = head_s[INSTR_W-1:0];
  assign out_opcode = head_s[INSTR_W-1 -: OPC_W];
  assign halted     = (state_r == FETCH_HALT) && (count_s == 2'd0);

endmodule
